// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: FSM states, frame geometry and parity helper.
package ps2_pkg;

  localparam int FRAME_BITS = 11;
  localparam int DATA_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [DATA_W-1:0] d, input logic p);
    return ^{p, d};
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchronisers for the PS/2 lines plus a run-length glitch filter on
// ps2_clk; emits the filtered clock, synchronised data and a falling-edge strobe.
module ps2_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic clrn,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_filt,
  output logic data_sync,
  output logic fall
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic [1:0]    clk_sync_reg;
  logic [1:0]    data_sync_reg;
  logic [CW-1:0] run_cnt_reg;
  logic          filt_reg;
  logic          fall_reg;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
      data_sync_reg <= {data_sync_reg[0], ps2_data};
    end
  end

  // The level flips on the FILT_LEN-th consecutive sample that disagrees with it.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      filt_reg    <= 1'b1;
      run_cnt_reg <= '0;
      fall_reg    <= 1'b0;
    end else begin
      fall_reg <= 1'b0;
      if (clk_sync_reg[1] != filt_reg) begin
        if (run_cnt_reg == CW'(FILT_LEN - 1)) begin
          filt_reg    <= clk_sync_reg[1];
          run_cnt_reg <= '0;
          fall_reg    <= filt_reg;
        end else begin
          run_cnt_reg <= run_cnt_reg + CW'(1);
        end
      end else begin
        run_cnt_reg <= '0;
      end
    end
  end

  assign clk_filt  = filt_reg;
  assign data_sync = data_sync_reg[1];
  assign fall      = fall_reg;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 frame receiver feeding a first-word-fall-through byte FIFO.
// Define PS2_PARITY_CHK_EN to reject bad-parity frames and drive the perr pulse.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int FILT_LEN = 4,
  parameter int TIMEOUT  = 4096
) (
  input  logic                       clk,
  input  logic                       clrn,
  input  logic                       ps2_clk,
  input  logic                       ps2_data,
  input  logic                       rdn,
  output logic [DATA_W-1:0]          data,
  output logic                       ready,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       perr
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int BW   = $clog2(DATA_W);

  logic clk_filt;
  logic data_sync;
  logic fall;

  ps2_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_filt (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .clk_filt  (clk_filt),
    .data_sync (data_sync),
    .fall      (fall)
  );

  ps2_state_t        state_reg, state_next;
  logic [BW-1:0]     bit_cnt_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] push_data_reg;
  logic              push_reg;
  logic              clk_filt_prev_reg;
  logic [TW-1:0]     timer_reg;
  logic              edge_seen;
  logic              timeout;
  logic              shift_en;
  logic              stop_en;
  logic              frame_ok;

  assign edge_seen = clk_filt ^ clk_filt_prev_reg;
  assign timeout   = (state_reg != ST_IDLE) && !edge_seen && (timer_reg == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    shift_en   = 1'b0;
    stop_en    = 1'b0;
    if (timeout) begin
      state_next = ST_IDLE;
    end else if (fall) begin
      case (state_reg)
        ST_IDLE:   if (!data_sync) state_next = ST_DATA;
        ST_DATA: begin
          shift_en = 1'b1;
          if (bit_cnt_reg == BW'(DATA_W - 1)) state_next = ST_PARITY;
        end
        ST_PARITY: state_next = ST_STOP;
        ST_STOP: begin
          stop_en    = 1'b1;
          state_next = ST_IDLE;
        end
        default:   state_next = ST_IDLE;
      endcase
    end
  end

`ifdef PS2_PARITY_CHK_EN
  logic par_reg;
  logic perr_reg;
  assign frame_ok = stop_en && data_sync && odd_parity_ok(shift_reg, par_reg);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      par_reg  <= 1'b0;
      perr_reg <= 1'b0;
    end else begin
      if (fall && state_reg == ST_PARITY) par_reg <= data_sync;
      perr_reg <= stop_en && !frame_ok;
    end
  end
  assign perr = perr_reg;
`else
  assign frame_ok = stop_en && data_sync;
  assign perr     = 1'b0;
`endif

  // Receiver datapath; the timer only runs while a frame is in progress.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt_reg       <= '0;
      shift_reg         <= '0;
      push_data_reg     <= '0;
      push_reg          <= 1'b0;
      clk_filt_prev_reg <= 1'b1;
      timer_reg         <= '0;
    end else begin
      clk_filt_prev_reg <= clk_filt;
      push_reg          <= frame_ok;
      if (frame_ok) push_data_reg <= shift_reg;
      if (state_reg == ST_IDLE) bit_cnt_reg <= '0;
      else if (shift_en)        bit_cnt_reg <= bit_cnt_reg + BW'(1);
      if (shift_en) shift_reg <= {data_sync, shift_reg[DATA_W-1:1]};
      if (state_reg == ST_IDLE || edge_seen || timeout) timer_reg <= '0;
      else                                              timer_reg <= timer_reg + TW'(1);
    end
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg, rd_next;
  logic [CNTW-1:0]   count_reg;
  logic [DATA_W-1:0] data_reg;
  logic              overflow_reg;
  logic              full;
  logic              pop;
  logic              wr_en;
  logic              drop;
  logic [DATA_W-1:0] head_next;

  assign full  = (count_reg == CNTW'(DEPTH));
  assign ready = (count_reg != '0);
  assign pop   = !rdn && ready;
  assign wr_en = push_reg && (!full || pop);
  assign drop  = push_reg && full && !pop;

  // Head after this cycle: bypass the byte being written when it lands at the new read slot.
  always_comb begin
    rd_next   = pop ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
    head_next = mem[rd_next];
    if (wr_en && wr_ptr_reg == rd_next) head_next = push_data_reg;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= push_data_reg;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      data_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      rd_ptr_reg <= rd_next;
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (wr_en && !pop)      count_reg <= count_reg + CNTW'(1);
      else if (pop && !wr_en) count_reg <= count_reg - CNTW'(1);
      if (wr_en || pop) data_reg <= head_next;
      overflow_reg <= drop || (overflow_reg && !pop);
    end
  end

  assign data     = data_reg;
  assign count    = count_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed self-checking bench for ps2_rx_fifo (default parameters).
module tb_ps2_rx_fifo;
  import ps2_pkg::*;

  localparam int DEPTH    = 8;
  localparam int FILT_LEN = 4;
  localparam int TIMEOUT  = 4096;
  localparam int HALF     = 10;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rdn = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic [3:0] count;
  logic       perr;

  int errors = 0;
  int checks = 0;
  int perr_cnt = 0;

  ps2_rx_fifo #(
    .DEPTH    (DEPTH),
    .FILT_LEN (FILT_LEN),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rdn      (rdn),
    .data     (data),
    .ready    (ready),
    .overflow (overflow),
    .count    (count),
    .perr     (perr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (perr === 1'b1) perr_cnt++;

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] d, input logic bad_par);
    return {1'b1, (~^d) ^ bad_par, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      wait_clks(HALF);
      ps2_clk = 1'b0;
      wait_clks(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par);
    $display("frame tx %02h bad_parity=%0d", d, bad_par);
    send_bits(frame_of(d, bad_par), 11);
    wait_clks(20);
  endtask

  task automatic pop_one();
    rdn = 1'b0;
    wait_clks(1);
    rdn = 1'b1;
  endtask

  // Drops rdn for exactly the cycle in which the receiver pushes.
  task automatic watch_push_and_pop();
    bit got = 0;
    for (int c = 0; c < 600 && !got; c++) begin
      @(negedge clk);
      if (dut.push_reg === 1'b1) begin
        rdn = 1'b0;
        wait_clks(1);
        rdn = 1'b1;
        got = 1;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL push_watch: got no push, required a push within 600 cycles");
    end
  endtask

  task automatic test_reset();
    wait_clks(3);
    checks++; if (ready !== 1'b0)    begin errors++; $display("FAIL reset_ready: got %b required 0", ready); end
    checks++; if (count !== 4'd0)    begin errors++; $display("FAIL reset_count: got %0d required 0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b required 0", overflow); end
    checks++; if (perr !== 1'b0)     begin errors++; $display("FAIL reset_perr: got %b required 0", perr); end
    checks++; if (data !== 8'h00)    begin errors++; $display("FAIL reset_data: got %02h required 00", data); end
    clrn = 1'b1;
    wait_clks(5);
  endtask

  task automatic test_single();
    send_frame(8'h1C, 1'b0);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b required 1", ready); end
    checks++; if (data !== 8'h1C) begin errors++; $display("FAIL single_data: got %02h required 1c", data); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d required 1", count); end
    pop_one();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL single_count_pop: got %0d required 0", count); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL single_ready_pop: got %b required 0", ready); end
  endtask

  task automatic test_parity();
    int snap = perr_cnt;
    send_frame(8'h5A, 1'b1);
`ifdef PS2_PARITY_CHK_EN
    checks++; if (perr_cnt - snap != 1) begin errors++; $display("FAIL parity_perr: got %0d pulses required 1", perr_cnt - snap); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL parity_count: got %0d required 0", count); end
`else
    checks++; if (perr_cnt != snap) begin errors++; $display("FAIL parity_perr: got %0d pulses required 0", perr_cnt - snap); end
    checks++; if (data !== 8'h5A) begin errors++; $display("FAIL parity_data: got %02h required 5a", data); end
    pop_one();
`endif
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL parity_drain: got %0d required 0", count); end
  endtask

  task automatic test_glitch();
    ps2_clk = 1'b0;
    wait_clks(FILT_LEN - 1);
    ps2_clk = 1'b1;
    wait_clks(20);
    checks++; if (dut.state_reg !== ST_IDLE) begin errors++; $display("FAIL glitch_state: got %0d required %0d", dut.state_reg, ST_IDLE); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL glitch_count: got %0d required 0", count); end
    send_frame(8'hF0, 1'b0);
    checks++; if (data !== 8'hF0) begin errors++; $display("FAIL glitch_data: got %02h required f0", data); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL glitch_frame_count: got %0d required 1", count); end
    pop_one();
  endtask

  task automatic test_timeout();
    int snap = perr_cnt;
    send_bits(frame_of(8'h77, 1'b0), 5);
    wait_clks(20);
    checks++; if (dut.state_reg !== ST_DATA) begin errors++; $display("FAIL timeout_midframe: got %0d required %0d", dut.state_reg, ST_DATA); end
    wait_clks(TIMEOUT + 10);
    checks++; if (dut.state_reg !== ST_IDLE) begin errors++; $display("FAIL timeout_state: got %0d required %0d", dut.state_reg, ST_IDLE); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL timeout_count: got %0d required 0", count); end
    checks++; if (perr_cnt != snap) begin errors++; $display("FAIL timeout_perr: got %0d pulses required 0", perr_cnt - snap); end
    send_frame(8'hAA, 1'b0);
    checks++; if (data !== 8'hAA || count !== 4'd1) begin errors++; $display("FAIL timeout_next: got %02h/%0d required aa/1", data, count); end
    pop_one();
  endtask

  task automatic test_reset_midframe();
    send_bits(frame_of(8'h33, 1'b0), 4);
    clrn = 1'b0;
    wait_clks(2);
    checks++; if (dut.state_reg !== ST_IDLE || count !== 4'd0) begin errors++; $display("FAIL midreset_state: got %0d/%0d required %0d/0", dut.state_reg, count, ST_IDLE); end
    clrn = 1'b1;
    wait_clks(5);
    send_frame(8'h3C, 1'b0);
    checks++; if (data !== 8'h3C || count !== 4'd1) begin errors++; $display("FAIL midreset_next: got %02h/%0d required 3c/1", data, count); end
    pop_one();
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0);
    checks++; if (count !== 4'd8)    begin errors++; $display("FAIL ovf_count: got %0d required 8", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b required 1", overflow); end
    checks++; if (data !== 8'h01)    begin errors++; $display("FAIL ovf_pop1: got %02h required 01", data); end
    rdn = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      wait_clks(1);
      checks++; if (data !== 8'(k)) begin errors++; $display("FAIL ovf_pop%0d: got %02h required %02h", k, data, 8'(k)); end
      if (k == 2) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b required 0", overflow); end
      end
    end
    wait_clks(2);
    rdn = 1'b1;
    checks++; if (count !== 4'd0 || ready !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %0d/%b required 0/0", count, ready); end
  endtask

  task automatic test_empty_push_pop();
    fork
      send_frame(8'h42, 1'b0);
      watch_push_and_pop();
    join
    checks++; if (count !== 4'd1 || data !== 8'h42 || ready !== 1'b1) begin errors++; $display("FAIL empty_pushpop: got %0d/%02h/%b required 1/42/1", count, data, ready); end
    pop_one();
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b0);
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_fill: got %0d required 8", count); end
    fork
      send_frame(8'h18, 1'b0);
      watch_push_and_pop();
    join
    checks++; if (count !== 4'd8)    begin errors++; $display("FAIL full_pushpop_count: got %0d required 8", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_pushpop_ovf: got %b required 0", overflow); end
    for (int k = 1; k <= 8; k++) begin
      checks++; if (data !== 8'h10 + 8'(k)) begin errors++; $display("FAIL full_drain%0d: got %02h required %02h", k, data, 8'h10 + 8'(k)); end
      pop_one();
    end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL full_drained: got %0d required 0", count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_glitch();
    test_timeout();
    test_reset_midframe();
    test_overflow();
    test_empty_push_pop();
    test_full_push_pop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries; power of two, range 2..64.
REQ-002 SHALL have parameter FILT_LEN, default 4, meaning consecutive equal samples needed to accept a ps2_clk level change.
REQ-003 SHALL have parameter TIMEOUT, default 4096, meaning clk cycles of no filtered ps2_clk edge that abort a frame in progress.
REQ-004 SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port clrn, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have ports ps2_clk and ps2_data, input, 1 each, meaning asynchronous PS/2 device lines.
REQ-007 SHALL have port rdn, input, 1, meaning active-low pop request, sampled every clk.
REQ-008 SHALL have port data, output, 8, meaning FIFO head byte (first-word fall-through).
REQ-009 SHALL have port ready, output, 1, meaning FIFO not empty.
REQ-010 SHALL have port overflow, output, 1, meaning sticky flag: a frame was dropped because the FIFO was full.
REQ-011 SHALL have port count, output, $clog2(DEPTH)+1, meaning current FIFO occupancy.
REQ-012 SHALL have port perr, output, 1, meaning one-cycle pulse for a frame rejected on parity or stop bit.

Function
REQ-013 SHALL pass ps2_clk and ps2_data through 2-flop synchronisers before any use.
REQ-014 SHALL change the filtered ps2_clk only after FILT_LEN consecutive identical synchronised samples; shorter glitches are ignored.
REQ-015 SHALL sample synchronised ps2_data on each filtered ps2_clk falling edge.
REQ-016 SHALL use the FSM IDLE->DATA (sampled start bit 0; a sampled 1 stays in IDLE), DATA->PARITY after 8 bits (LSB first), PARITY->STOP, STOP->IDLE.
REQ-017 SHALL validate the frame in STOP: stop bit must be 1, with parity handling per REQ-028/029.
REQ-018 SHALL push a valid byte in the cycle after the stop-bit edge; data and ready update one cycle after that push.
REQ-019 SHALL return to IDLE and discard partial bits when TIMEOUT cycles pass without a filtered edge outside IDLE; perr stays 0.
REQ-020 SHALL pop on every clk where rdn=0 and ready=1; holding rdn low pops once per cycle; a pop when empty is ignored.
REQ-021 SHALL, on a push while full with no same-cycle pop, drop the byte and set overflow; contents and count stay unchanged.
REQ-022 SHALL accept a push while full when a pop occurs in the same cycle; count is unchanged and overflow is not set.
REQ-023 SHALL, on a push and pop together while empty, store the byte and ignore the pop, leaving count=1.
REQ-024 SHALL clear overflow on any accepted pop, unless a new drop occurs in the same cycle, in which case overflow stays 1.
REQ-025 SHALL wrap read and write pointers modulo DEPTH; full when count==DEPTH.

Reset
REQ-026 SHALL, while clrn=0, asynchronously force FSM=IDLE, pointers=0, count=0, ready=0, overflow=0, perr=0, data=8'h00, filter and synchronisers to idle-high, and timeout counter to 0.
REQ-027 SHALL, on reset mid-frame, discard the partial frame; the first frame after release is received normally.

Configuration
REQ-028 SHALL, with PS2_PARITY_CHK_EN defined, require odd parity over data plus parity bit; on parity or stop failure, drop the frame and pulse perr for one cycle.
REQ-029 SHALL, with PS2_PARITY_CHK_EN undefined, sample and ignore the parity bit, drop bad-stop frames silently, and tie perr to 0.

Structure
REQ-030 SHALL place the FSM state enum, the frame bit count (11), and the data width (8) in shared package ps2_pkg.
REQ-031 SHALL implement synchroniser plus FILT_LEN filter as sub-module ps2_filter, outputting filtered clock, synchronised data, and a falling-edge strobe.

Verification
REQ-032 SHALL verify: send 8'h1C with correct parity, then pop -> ready=1 and data=8'h1C before pop, count 1->0, ready=0 after pop.
REQ-033 SHALL verify: DEPTH=8, send 9 frames 8'h01..8'h09 with no pops -> count=8, overflow=1, pops return 8'h01..8'h08, overflow=0 after the first pop.
REQ-034 SHALL verify: send 8'h5A with the wrong parity bit -> with PS2_PARITY_CHK_EN, perr pulses once and count stays 0; without it, data=8'h5A.
REQ-035 SHALL verify: FILT_LEN-1-cycle low glitch on ps2_clk in IDLE -> no state change and no push; then a full 8'hF0 frame is received correctly.
REQ-036 SHALL verify: stop ps2_clk after 4 data bits for TIMEOUT+10 cycles -> FSM returns to IDLE, nothing pushed; the next 8'hAA frame is received intact.
REQ-037 SHALL verify: with FIFO full, a push and rdn=0 in the same cycle -> count stays 8, overflow stays 0, and the new byte appears last.
